// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage that sits right after the program counter.
// Latches the requested PC, runs a req/ack transaction on the instruction
// memory port, holds the returned word for decode and drops in-flight
// fetches on a redirect (flush). A stuck memory is abandoned after
// TIMEOUT_CYCLES waiting cycles.
// Optional build macro FETCH_ALIGN_CHECK_EN: misaligned PCs are trapped
// without touching memory and reported on the extra misalign_err output.

module instr_fetch #(
  parameter logic [31:0] DEFAULT_ENTRY  = 32'h0040_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] NOP_INSTR      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        pc_req,
  input  logic        flush,
  output logic        fetch_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_taken,
  output logic        timeout_err
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        misalign_err
`endif
);

  localparam logic [8:0] TIMEOUT_LIMIT = 9'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN, HOLD} state_t;

  state_t      state;
  state_t      state_next;
  logic [7:0]  wait_count;
  logic [7:0]  wait_count_next;
  logic [8:0]  wait_count_inc;
  logic        timeout_hit;
  logic        timeout_fire;
  logic        capture;
  logic        accept;
  logic        misaligned;
  logic        issue;
  logic [31:0] instr_word;

  // Decode whether a PC is accepted/issued this cycle and whether the memory wait has expired
  always_comb begin
    accept = fetch_ready & pc_req;
`ifdef FETCH_ALIGN_CHECK_EN
    misaligned = |pc[1:0];
`else
    misaligned = 1'b0;
`endif
    issue          = accept & ~misaligned;
    wait_count_inc = {1'b0, wait_count} + 9'd1;
    timeout_hit    = ~imem_ack & (wait_count_inc >= TIMEOUT_LIMIT);
    capture        = (state == REQ) & imem_ack & ~flush;
    timeout_fire   = ((state == REQ) & ~flush & timeout_hit) |
                     ((state == DRAIN) & timeout_hit);
  end

  // State register and memory-wait counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wait_count <= 8'd0;
    end else begin
      state      <= state_next;
      wait_count <= wait_count_next;
    end
  end

  // Next-state logic; flush outranks ack/timeout, which outrank instr_taken, then pc_req
  always_comb begin
    state_next      = state;
    wait_count_next = wait_count;
    case (state)
      IDLE: begin
        if (issue) state_next = REQ;
      end
      REQ: begin
        if (flush & imem_ack) begin
          state_next      = IDLE;
          wait_count_next = 8'd0;
        end else if (flush) begin
          state_next      = DRAIN;
          wait_count_next = wait_count_inc[7:0];
        end else if (imem_ack) begin
          state_next      = HOLD;
          wait_count_next = 8'd0;
        end else if (timeout_hit) begin
          state_next      = IDLE;
          wait_count_next = 8'd0;
        end else begin
          wait_count_next = wait_count_inc[7:0];
        end
      end
      DRAIN: begin
        if (imem_ack | timeout_hit) begin
          state_next      = IDLE;
          wait_count_next = 8'd0;
        end else begin
          wait_count_next = wait_count_inc[7:0];
        end
      end
      HOLD: begin
        if (flush) state_next = IDLE;
        else if (instr_taken) state_next = issue ? REQ : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from the current state
  always_comb begin
    fetch_ready = ~flush & ((state == IDLE) | ((state == HOLD) & instr_taken));
    imem_req    = (state == REQ) | (state == DRAIN);
    instr_valid = (state == HOLD);
    instr       = instr_valid ? instr_word : NOP_INSTR;
  end

  // Address latch, fetched word capture and one-cycle error pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imem_addr    <= DEFAULT_ENTRY;
      instr_word   <= NOP_INSTR;
      instr_pc     <= DEFAULT_ENTRY;
      timeout_err  <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      misalign_err <= 1'b0;
`endif
    end else begin
      timeout_err <= timeout_fire;
      if (issue) imem_addr <= pc & ~32'h3;
      if (capture) begin
        instr_word <= imem_rdata;
        instr_pc   <= imem_addr;
      end
`ifdef FETCH_ALIGN_CHECK_EN
      misalign_err <= accept & misaligned;
      if (accept & misaligned) instr_pc <= pc;
`endif
    end
  end

endmodule
